// File: rtl/gpr_hilo_file_mp_pkg.sv
// rtl/gpr_hilo_file_mp_pkg.sv - shared constants and slicing helpers for the GPR/HI/LO file
// Purpose: default widths, the hardwired-zero register index, and helpers that
//          locate port i inside a flattened {port N-1, ..., port 0} vector.
// Ports:   none (package).
package gpr_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int AW_DEF     = 5;

  localparam logic [AW_DEF-1:0] REG_ZERO = '0;

  // Bit offset of port idx in a flattened vector of w-bit fields.
  function automatic int lsb_of(input int idx, input int w);
    return idx * w;
  endfunction

  // Extract field idx of width AW_DEF from a flattened address vector of up to 8 ports.
  function automatic logic [AW_DEF-1:0] addr_at(input logic [8*AW_DEF-1:0] vec, input int idx);
    return vec[lsb_of(idx, AW_DEF) +: AW_DEF];
  endfunction

endpackage

// File: rtl/gpr_hilo_file_mp_if.sv
// rtl/gpr_hilo_file_mp_if.sv - ID-stage access bus for the GPR/HI/LO file
// Purpose: groups read ports, write ports, scoreboard controls and HI/LO access.
// Ports:   master = ID stage (drives addresses/writes, sees data/busy),
//          slave  = register file.
interface gpr_hilo_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 5,
  parameter int NUM_RD = 4,
  parameter int NUM_WR = 2
);
  logic [NUM_RD*AW-1:0]     rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*AW-1:0]     wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic [NUM_WR-1:0]        wr_clr;
  logic [NUM_WR-1:0]        sb_set;
  logic [NUM_WR*AW-1:0]     sb_addr;
  logic                     sb_flush;
  logic                     hi_we;
  logic                     lo_we;
  logic [DATA_W-1:0]        hi_wdata;
  logic [DATA_W-1:0]        lo_wdata;
  logic [DATA_W-1:0]        hi_rdata;
  logic [DATA_W-1:0]        lo_rdata;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, wr_clr, sb_set, sb_addr, sb_flush,
           hi_we, lo_we, hi_wdata, lo_wdata,
    input  rd_data, rd_busy, hi_rdata, lo_rdata
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, wr_clr, sb_set, sb_addr, sb_flush,
           hi_we, lo_we, hi_wdata, lo_wdata,
    output rd_data, rd_busy, hi_rdata, lo_rdata
  );
endinterface

// File: rtl/gpr_hilo_file_mp_scoreboard.sv
// rtl/gpr_hilo_file_mp_scoreboard.sv - per-GPR busy scoreboard with set/clear/flush
// Purpose: tracks in-flight producers per GPR; reports busy per read port, masking
//          registers whose producer retires this cycle (value is bypassed).
// Ports:   clk, rst (sync, active-high); sb_set/sb_addr issue-time sets; sb_flush;
//          wr_en/wr_clr/wr_addr retiring writes; rd_addr in, rd_busy out.
module gpr_scoreboard
  import gpr_pkg::*;
#(
  parameter int NREG   = 32,
  parameter int AW     = AW_DEF,
  parameter int NUM_RD = 4,
  parameter int NUM_WR = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_WR-1:0]    sb_set_i,
  input  logic [NUM_WR*AW-1:0] sb_addr_i,
  input  logic                 sb_flush_i,
  input  logic [NUM_WR-1:0]    wr_en_i,
  input  logic [NUM_WR-1:0]    wr_clr_i,
  input  logic [NUM_WR*AW-1:0] wr_addr_i,
  input  logic [NUM_RD*AW-1:0] rd_addr_i,
  output logic [NUM_RD-1:0]    rd_busy_o
);

  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] set_hit, clr_hit;

  always_comb begin
    set_hit = '0;
    clr_hit = '0;
    for (int r = 1; r < NREG; r++) begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (sb_set_i[k] && sb_addr_i[lsb_of(k, AW) +: AW] == AW'(r))
          set_hit[r] = 1'b1;
        if (wr_en_i[k] && wr_clr_i[k] && wr_addr_i[lsb_of(k, AW) +: AW] == AW'(r))
          clr_hit[r] = 1'b1;
      end
    end
  end

  // A new producer outranks both the flush and a retiring producer.
  always_comb begin
    busy_d = '0;
    for (int r = 1; r < NREG; r++) begin
      if (set_hit[r])       busy_d[r] = 1'b1;
      else if (sb_flush_i)  busy_d[r] = 1'b0;
      else if (clr_hit[r])  busy_d[r] = 1'b0;
      else                  busy_d[r] = busy_q[r];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  always_comb begin
    rd_busy_o = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_busy_o[i] = busy_q[rd_addr_i[lsb_of(i, AW) +: AW]] &
                     ~clr_hit[rd_addr_i[lsb_of(i, AW) +: AW]];
    end
  end

endmodule

// File: rtl/gpr_hilo_file_mp.sv
// rtl/gpr_hilo_file_mp.sv - multi-port GPR file with HI/LO and busy scoreboard
// Purpose: NUM_RD combinational read ports with write-through bypass, NUM_WR write
//          ports (highest index wins on collision), r0 hardwired to zero, HI/LO
//          with bypass, and a busy scoreboard for RAW hazard detection.
// Ports:   clk, rst (sync, active-high); bus = gpr_hilo_file_mp_if slave modport.
module gpr_hilo_file_mp
  import gpr_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREG   = 32,
  parameter int AW     = AW_DEF,
  parameter int NUM_RD = 4,
  parameter int NUM_WR = 2
) (
  input logic            clk,
  input logic            rst,
  gpr_hilo_file_mp_if.slave bus
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;

  // Ascending port order makes the highest-indexed port win.
  always_comb begin
    for (int r = 0; r < NREG; r++) regs_d[r] = regs_q[r];
    for (int k = 0; k < NUM_WR; k++) begin
      if (bus.wr_en[k] && bus.wr_addr[lsb_of(k, AW) +: AW] != AW'(REG_ZERO))
        regs_d[bus.wr_addr[lsb_of(k, AW) +: AW]] = bus.wr_data[lsb_of(k, DATA_W) +: DATA_W];
    end
    regs_d[0] = '0;
  end

  assign hi_d = bus.hi_we ? bus.hi_wdata : hi_q;
  assign lo_d = bus.lo_we ? bus.lo_wdata : lo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= regs_d[r];
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  always_comb begin
    bus.rd_data = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      bus.rd_data[lsb_of(i, DATA_W) +: DATA_W] = regs_q[bus.rd_addr[lsb_of(i, AW) +: AW]];
      for (int k = 0; k < NUM_WR; k++) begin
        if (bus.wr_en[k] && bus.wr_addr[lsb_of(k, AW) +: AW] == bus.rd_addr[lsb_of(i, AW) +: AW])
          bus.rd_data[lsb_of(i, DATA_W) +: DATA_W] = bus.wr_data[lsb_of(k, DATA_W) +: DATA_W];
      end
      // r0 reads zero even while a dropped write targets it.
      if (bus.rd_addr[lsb_of(i, AW) +: AW] == AW'(REG_ZERO))
        bus.rd_data[lsb_of(i, DATA_W) +: DATA_W] = '0;
    end
  end

  assign bus.hi_rdata = hi_d;
  assign bus.lo_rdata = lo_d;

  gpr_scoreboard #(
    .NREG   (NREG),
    .AW     (AW),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .sb_set_i   (bus.sb_set),
    .sb_addr_i  (bus.sb_addr),
    .sb_flush_i (bus.sb_flush),
    .wr_en_i    (bus.wr_en),
    .wr_clr_i   (bus.wr_clr),
    .wr_addr_i  (bus.wr_addr),
    .rd_addr_i  (bus.rd_addr),
    .rd_busy_o  (bus.rd_busy)
  );

endmodule

// File: tb/tb_gpr_hilo_file_mp.sv
// tb/tb_gpr_hilo_file_mp.sv - directed self-checking bench for gpr_hilo_file_mp
module tb_gpr_hilo_file_mp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  gpr_hilo_file_mp_if bus ();

  gpr_hilo_file_mp dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic idle();
    bus.wr_en    = '0;
    bus.wr_clr   = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.sb_set   = '0;
    bus.sb_addr  = '0;
    bus.sb_flush = 1'b0;
    bus.hi_we    = 1'b0;
    bus.lo_we    = 1'b0;
    bus.hi_wdata = '0;
    bus.lo_wdata = '0;
  endtask

  task automatic set_rd(input int p, input logic [4:0] a);
    bus.rd_addr[p*5 +: 5] = a;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d, input logic clr);
    bus.wr_en[p]          = 1'b1;
    bus.wr_clr[p]         = clr;
    bus.wr_addr[p*5 +: 5] = a;
    bus.wr_data[p*32 +: 32] = d;
  endtask

  task automatic sbset(input int p, input logic [4:0] a);
    bus.sb_set[p]         = 1'b1;
    bus.sb_addr[p*5 +: 5] = a;
  endtask

  function automatic logic [31:0] rdd(input int p);
    return bus.rd_data[p*32 +: 32];
  endfunction

  // Advance one clock and land mid-low-phase, away from the active edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    idle();
    bus.rd_addr = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    set_rd(0, 5'd1); set_rd(1, 5'd2); set_rd(2, 5'd3); set_rd(3, 5'd31);
    #1;
    for (int p = 0; p < 4; p++) check($sformatf("reset_rd_data%0d", p), rdd(p), 32'h0);
    check("reset_rd_busy", {28'h0, bus.rd_busy}, 32'h0);
    check("reset_hi", bus.hi_rdata, 32'h0);
    check("reset_lo", bus.lo_rdata, 32'h0);

    // Both write ports target r5: port 1 wins, bypassed and committed.
    @(negedge clk);
    wr(0, 5'd5, 32'hAAAA0000, 1'b0);
    wr(1, 5'd5, 32'h5555FFFF, 1'b0);
    set_rd(0, 5'd5);
    #1;
    check("r5_collision_bypass", rdd(0), 32'h5555FFFF);
    @(negedge clk);
    idle();
    #1;
    check("r5_collision_stored", rdd(0), 32'h5555FFFF);

    // r0 write and r0 scoreboard set are both dropped.
    @(negedge clk);
    wr(0, 5'd0, 32'hDEADBEEF, 1'b0);
    sbset(0, 5'd0);
    set_rd(0, 5'd0);
    #1;
    check("r0_same_data", rdd(0), 32'h0);
    check("r0_same_busy", {31'h0, bus.rd_busy[0]}, 32'h0);
    @(negedge clk);
    idle();
    #1;
    check("r0_after_data", rdd(0), 32'h0);
    check("r0_after_busy", {31'h0, bus.rd_busy[0]}, 32'h0);

    // Set r7 busy, then retire it with a clearing write.
    @(negedge clk);
    sbset(0, 5'd7);
    set_rd(1, 5'd7);
    #1;
    check("r7_set_not_visible", {31'h0, bus.rd_busy[1]}, 32'h0);
    @(negedge clk);
    idle();
    #1;
    check("r7_busy", {31'h0, bus.rd_busy[1]}, 32'h1);
    @(negedge clk);
    wr(0, 5'd7, 32'h12345678, 1'b1);
    #1;
    check("r7_clr_busy_same", {31'h0, bus.rd_busy[1]}, 32'h0);
    check("r7_clr_data_same", rdd(1), 32'h12345678);
    @(negedge clk);
    idle();
    #1;
    check("r7_busy_after", {31'h0, bus.rd_busy[1]}, 32'h0);
    check("r7_data_after", rdd(1), 32'h12345678);

    // Non-clearing write leaves busy untouched.
    @(negedge clk);
    sbset(0, 5'd8);
    @(negedge clk);
    idle();
    wr(1, 5'd8, 32'h00000088, 1'b0);
    set_rd(2, 5'd8);
    #1;
    check("r8_noclr_busy_same", {31'h0, bus.rd_busy[2]}, 32'h1);
    step();
    idle();
    #0;
    check("r8_noclr_busy_after", {31'h0, bus.rd_busy[2]}, 32'h1);
    check("r8_noclr_data", rdd(2), 32'h00000088);

    // Set on port 1 beats a clearing write on port 0 for r9.
    @(negedge clk);
    sbset(1, 5'd9);
    wr(0, 5'd9, 32'h00000099, 1'b1);
    set_rd(0, 5'd9);
    #1;
    check("r9_same_busy", {31'h0, bus.rd_busy[0]}, 32'h0);
    @(negedge clk);
    idle();
    #1;
    check("r9_busy_next", {31'h0, bus.rd_busy[0]}, 32'h1);
    check("r9_data", rdd(0), 32'h00000099);

    // Flush with a same-cycle set to r10: only r10 stays busy.
    @(negedge clk);
    bus.sb_flush = 1'b1;
    sbset(0, 5'd10);
    set_rd(3, 5'd10);
    #1;
    check("flush_same_r9", {31'h0, bus.rd_busy[0]}, 32'h1);
    @(negedge clk);
    idle();
    #1;
    check("flush_r9", {31'h0, bus.rd_busy[0]}, 32'h0);
    check("flush_r7", {31'h0, bus.rd_busy[1]}, 32'h0);
    check("flush_r8", {31'h0, bus.rd_busy[2]}, 32'h0);
    check("flush_r10", {31'h0, bus.rd_busy[3]}, 32'h1);

    // HI/LO bypass and hold.
    @(negedge clk);
    bus.hi_we = 1'b1; bus.hi_wdata = 32'h11111111;
    bus.lo_we = 1'b1; bus.lo_wdata = 32'h22222222;
    #1;
    check("hi_bypass", bus.hi_rdata, 32'h11111111);
    check("lo_bypass", bus.lo_rdata, 32'h22222222);
    @(negedge clk);
    idle();
    bus.hi_wdata = 32'hFFFFFFFF;
    bus.lo_wdata = 32'hEEEEEEEE;
    #1;
    check("hi_hold", bus.hi_rdata, 32'h11111111);
    check("lo_hold", bus.lo_rdata, 32'h22222222);

    // Reset overrides pending writes and sets.
    @(negedge clk);
    rst = 1'b1;
    wr(0, 5'd5, 32'hCAFEF00D, 1'b0);
    wr(1, 5'd12, 32'h0BADF00D, 1'b0);
    sbset(0, 5'd11);
    bus.hi_we = 1'b1; bus.hi_wdata = 32'h33333333;
    bus.lo_we = 1'b1; bus.lo_wdata = 32'h44444444;
    @(negedge clk);
    rst = 1'b0;
    idle();
    set_rd(0, 5'd5); set_rd(1, 5'd11); set_rd(2, 5'd12); set_rd(3, 5'd10);
    #1;
    for (int p = 0; p < 4; p++) check($sformatf("rst2_rd_data%0d", p), rdd(p), 32'h0);
    check("rst2_rd_busy", {28'h0, bus.rd_busy}, 32'h0);
    check("rst2_hi", bus.hi_rdata, 32'h0);
    check("rst2_lo", bus.lo_rdata, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
